icache_set_refill: RTL and testbench
====================================

ICACHE_SET_REFILL -- requirements
Module: icache_set_refill

Interface
REQ-001 Parameter B, default 64, block size in bytes; power of 2, >= 8.
REQ-002 Parameter NUM_TAG_BITS, default 20, tag width.
REQ-003 Parameter E, default 4, associativity; power of 2, >= 2.
REQ-004 Parameter BEAT_W, default 64, refill beat width in bits; one of 32/64/128, <= 8*B; BEATS = 8*B/BEAT_W.
REQ-005 clk_i  in  1  sole clock; all state changes on rising edge.
REQ-006 reset_ni  in  1  asynchronous, active-low reset.
REQ-007 active_set_i  in  1  this set is addressed this cycle.
REQ-008 rep_enable_i  in  1  permits starting a refill on a miss.
REQ-009 block_i  in  $clog2(B)  byte offset within block.
REQ-010 tag_i  in  NUM_TAG_BITS  lookup tag.
REQ-011 invalidate_i  in  1  clear all ways (fence.i).
REQ-012 l2_valid_i  in  1  refill beat present on l2_data_i.
REQ-013 l2_data_i  in  BEAT_W  refill beat, lowest-addressed beat first.
REQ-014 refill_req_o  out  1  high throughout FILL state.
REQ-015 data_o  out  32  instruction word at block_i[b-1:2] of hit way.
REQ-016 hit_o  out  1  combinational hit.
REQ-017 miss_o  out  1  active_set_i and not hit_o.
REQ-018 busy_o  out  1  state != IDLE.
REQ-019 refill_done_o  out  1  one-cycle pulse in COMMIT.

Function
REQ-020 Per way: tag, valid bit, age in 0..E-1; ages SHALL always form a permutation of 0..E-1.
REQ-021 hit_o = active_set_i, state IDLE, and some valid way tag equals tag_i; zero-cycle latency; data_o from that way, else 0.
REQ-022 data_o lane select: beat = word_index / (BEAT_W/32), lane = word_index mod (BEAT_W/32).
REQ-023 FSM states IDLE, FILL, COMMIT.
REQ-024 IDLE->FILL when miss_o and rep_enable_i and not invalidate_i; same edge latches tag_i and victim way.
REQ-025 Victim: lowest-index invalid way; if all valid, the way with age E-1.
REQ-026 In FILL, each cycle with l2_valid_i writes l2_data_i to beat slot beat_cnt of victim, then beat_cnt increments; on the edge accepting beat BEATS-1, state -> COMMIT.
REQ-027 Cycles in FILL without l2_valid_i: no state change (stall indefinitely).
REQ-028 COMMIT (exactly one cycle): victim tag <- latched tag, valid <- 1, victim age <- 0, ways with age < old victim age increment; refill_done_o = 1; next state IDLE, beat_cnt <- 0.
REQ-029 Hit in IDLE: hit way age <- 0, ways with age < hit age increment, others unchanged.
REQ-030 During FILL/COMMIT: hit_o = 0, miss_o = active_set_i, tag_i/block_i changes ignored for refill; no LRU update from lookups.
REQ-031 l2_valid_i in IDLE or COMMIT is ignored.
REQ-032 invalidate_i in IDLE/COMMIT: all valid bits cleared next edge (overrides COMMIT valid set); ages unchanged.
REQ-033 invalidate_i in FILL: refill aborted, state -> IDLE, beat_cnt <- 0, valids cleared, no tag written.
REQ-034 Miss with rep_enable_i = 0: no state, LRU, or valid change.
REQ-035 Total miss penalty with continuous beats: BEATS + 2 cycles from miss edge to hit.

Reset
REQ-036 reset_ni low: immediately state IDLE, beat_cnt 0, all valid 0, age[i] = i, refill_req_o 0, busy_o 0, refill_done_o 0, hit_o 0; tags/data undefined.
REQ-037 Reset asserted mid-FILL abandons refill with same values as REQ-036.

Verification (E=4, B=64, BEAT_W=64, BEATS=8)
REQ-038 After reset, tag 0x12345 miss, rep_enable 1, 8 beats 0x0..7 each {2k+1,2k} -> refill_done_o one cycle after 8th beat, way0 valid, block_i=0x0C reads 0x00000003.
REQ-039 Fill ways 0-3 with tags A,B,C,D; hit A; miss E -> victim way1 (tag B, age 3), refill overwrites way1.
REQ-040 l2_valid_i toggling every other cycle -> refill_req_o held, 8 beats accepted, done after 16+2 cycles.
REQ-041 invalidate_i at beat 4 of FILL -> busy_o 0 next cycle, all lookups miss, no tag written.
REQ-042 reset_ni pulsed low at beat 3 -> outputs per REQ-036 without clock edge; subsequent miss restarts at beat 0.
REQ-043 Random hit/miss stream 10k cycles -> ages remain permutation; model-matched data_o on every hit.

Source files
------------

// File: rtl/icache_set_refill_if.sv
// Lookup/refill bus of one instruction-cache set.
// master: drives the lookup request and the L2 refill beats, receives the lookup result and refill status.
// slave : the cache set (icache_set_refill).
interface icache_set_refill_if #(
   parameter int unsigned B            = 64,
   parameter int unsigned NUM_TAG_BITS = 20,
   parameter int unsigned BEAT_W       = 64
);
   localparam int unsigned OFF_W = $clog2(B);

   logic                    active_set_i;
   logic                    rep_enable_i;
   logic [OFF_W-1:0]        block_i;
   logic [NUM_TAG_BITS-1:0] tag_i;
   logic                    invalidate_i;
   logic                    l2_valid_i;
   logic [BEAT_W-1:0]       l2_data_i;
   logic                    refill_req_o;
   logic [31:0]             data_o;
   logic                    hit_o;
   logic                    miss_o;
   logic                    busy_o;
   logic                    refill_done_o;

   modport master (
      output active_set_i, rep_enable_i, block_i, tag_i, invalidate_i, l2_valid_i, l2_data_i,
      input  refill_req_o, data_o, hit_o, miss_o, busy_o, refill_done_o
   );

   modport slave (
      input  active_set_i, rep_enable_i, block_i, tag_i, invalidate_i, l2_valid_i, l2_data_i,
      output refill_req_o, data_o, hit_o, miss_o, busy_o, refill_done_o
   );
endinterface

// File: rtl/icache_set_refill.sv
// One E-way set of an instruction cache with true-LRU ages and a beat-wise L2 refill engine.
// Ports: clk_i, reset_ni (async, active-low) plus bus (icache_set_refill_if.slave):
//   lookup  : active_set_i, tag_i, block_i -> hit_o, miss_o, data_o (zero-latency)
//   refill  : rep_enable_i, l2_valid_i, l2_data_i -> refill_req_o, busy_o, refill_done_o
//   control : invalidate_i clears every valid bit (aborts a refill in progress)
module icache_set_refill #(
   parameter int unsigned B            = 64,
   parameter int unsigned NUM_TAG_BITS = 20,
   parameter int unsigned E            = 4,
   parameter int unsigned BEAT_W       = 64
) (
   input logic               clk_i,
   input logic               reset_ni,
   icache_set_refill_if.slave bus
);
   localparam int unsigned OFF_W  = $clog2(B);
   localparam int unsigned WORD_W = OFF_W - 2;
   localparam int unsigned BEATS  = 8 * B / BEAT_W;
   localparam int unsigned LANES  = BEAT_W / 32;
   localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned WAY_W  = $clog2(E);
   localparam int unsigned AGE_W  = WAY_W;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] FILL   = 2'd1;
   localparam logic [1:0] COMMIT = 2'd2;

   logic [1:0]              state_q, state_d;
   logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
   logic [E-1:0]            valid_q, valid_d;
   logic [AGE_W-1:0]        age_q [E];
   logic [AGE_W-1:0]        age_d [E];
   logic [NUM_TAG_BITS-1:0] tag_q [E];
   logic [NUM_TAG_BITS-1:0] tag_d [E];
   logic [BEAT_W-1:0]       data_q [E][BEATS];
   logic [BEAT_W-1:0]       data_d [E][BEATS];
   logic [NUM_TAG_BITS-1:0] fill_tag_q, fill_tag_d;
   logic [WAY_W-1:0]        victim_q, victim_d;

   logic                    hit_c;
   logic [WAY_W-1:0]        hit_way;
   logic [WAY_W-1:0]        victim_c;
   logic                    lru_en;
   logic [WAY_W-1:0]        lru_way;

   // Tag compare; only meaningful in IDLE, refill states force a miss.
   always_comb begin
      logic found;
      hit_way = '0;
      found   = 1'b0;
      for (int unsigned i = 0; i < E; i++) begin
         if (!found && valid_q[i] && (tag_q[i] == bus.tag_i)) begin
            hit_way = WAY_W'(i);
            found   = 1'b1;
         end
      end
      hit_c = found && bus.active_set_i && (state_q == IDLE);
   end

   // Word select: beat = word / LANES, lane = word mod LANES.
   always_comb begin
      logic [WORD_W-1:0] word_idx;
      logic [CNT_W-1:0]  beat_sel;
      int unsigned       lane_sel;
      logic [BEAT_W-1:0] sel_beat;
      logic [31:0]       word;
      word_idx = bus.block_i[OFF_W-1:2];
      beat_sel = CNT_W'(32'(word_idx) / LANES);
      lane_sel = 32'(word_idx) % LANES;
      sel_beat = data_q[hit_way][beat_sel];
      word     = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         if (lane_sel == l) word = sel_beat[l*32 +: 32];
      end
      bus.data_o = hit_c ? word : 32'd0;
   end

   // Victim: lowest-index invalid way, otherwise the oldest (age E-1).
   always_comb begin
      logic found;
      victim_c = '0;
      found    = 1'b0;
      for (int unsigned i = 0; i < E; i++) begin
         if (!found && !valid_q[i]) begin
            victim_c = WAY_W'(i);
            found    = 1'b1;
         end
      end
      if (!found) begin
         for (int unsigned i = 0; i < E; i++) begin
            if (age_q[i] == AGE_W'(E - 1)) victim_c = WAY_W'(i);
         end
      end
   end

   // Next-state logic for the FSM, arrays and LRU ages.
   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      valid_d    = valid_q;
      tag_d      = tag_q;
      data_d     = data_q;
      fill_tag_d = fill_tag_q;
      victim_d   = victim_q;
      lru_en     = 1'b0;
      lru_way    = hit_way;
      case (state_q)
         IDLE: begin
            if (bus.invalidate_i) begin
               valid_d = '0;
            end else if (hit_c) begin
               lru_en  = 1'b1;
               lru_way = hit_way;
            end else if (bus.miss_o && bus.rep_enable_i) begin
               state_d    = FILL;
               fill_tag_d = bus.tag_i;
               victim_d   = victim_c;
               beat_cnt_d = '0;
            end
         end
         FILL: begin
            if (bus.invalidate_i) begin
               state_d    = IDLE;
               beat_cnt_d = '0;
               valid_d    = '0;
            end else if (bus.l2_valid_i) begin
               data_d[victim_q][beat_cnt_q] = bus.l2_data_i;
               if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
                  state_d    = COMMIT;
                  beat_cnt_d = '0;
               end else begin
                  beat_cnt_d = beat_cnt_q + CNT_W'(1);
               end
            end
         end
         COMMIT: begin
            tag_d[victim_q]   = fill_tag_q;
            valid_d[victim_q] = 1'b1;
            lru_en            = 1'b1;
            lru_way           = victim_q;
            state_d           = IDLE;
            beat_cnt_d        = '0;
            // invalidate wins over the valid bit set by the commit
            if (bus.invalidate_i) valid_d = '0;
         end
         default: begin
            state_d    = IDLE;
            beat_cnt_d = '0;
         end
      endcase

      // Move lru_way to age 0; younger ways age by one, keeping a permutation.
      age_d = age_q;
      if (lru_en) begin
         for (int unsigned i = 0; i < E; i++) begin
            if (age_q[i] < age_q[lru_way]) age_d[i] = age_q[i] + AGE_W'(1);
         end
         age_d[lru_way] = '0;
      end
   end

   // Control state, valid bits and ages.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= IDLE;
         beat_cnt_q <= '0;
         valid_q    <= '0;
         fill_tag_q <= '0;
         victim_q   <= '0;
         for (int unsigned i = 0; i < E; i++) age_q[i] <= AGE_W'(i);
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         valid_q    <= valid_d;
         fill_tag_q <= fill_tag_d;
         victim_q   <= victim_d;
         age_q      <= age_d;
      end
   end

   // Tag and data storage are not reset; valid bits gate their use.
   always_ff @(posedge clk_i) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

   assign bus.hit_o         = hit_c;
   assign bus.miss_o        = bus.active_set_i && !hit_c;
   assign bus.busy_o        = (state_q != IDLE);
   assign bus.refill_req_o  = (state_q == FILL);
   assign bus.refill_done_o = (state_q == COMMIT);
endmodule

// File: tb/tb_icache_set_refill.sv
// Directed bench for icache_set_refill (E=4, B=64, BEAT_W=64, 8 beats per refill).
module tb_icache_set_refill;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   icache_set_refill_if #(.B(64), .NUM_TAG_BITS(20), .BEAT_W(64)) bus ();

   icache_set_refill #(.B(64), .NUM_TAG_BITS(20), .E(4), .BEAT_W(64)) dut (
      .clk_i    (clk),
      .reset_ni (rst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   typedef struct {
      logic        act;
      logic [19:0] tag;
      logic [5:0]  blk;
      logic        exp_hit;
      logic        exp_miss;
      logic [31:0] exp_data;
   } vec_t;

   localparam int NV = 12;
   vec_t vecs [NV];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] beat(input logic [31:0] base, input int k);
      return {base + 32'(2 * k + 1), base + 32'(2 * k)};
   endfunction

   task automatic lookup(input string nm, input logic act, input logic [19:0] t,
                         input logic [5:0] blk, input logic eh, input logic em,
                         input logic [31:0] ed);
      @(negedge clk);
      bus.active_set_i = act;
      bus.tag_i        = t;
      bus.block_i      = blk;
      bus.rep_enable_i = 1'b0;
      bus.l2_valid_i   = 1'b0;
      #1;
      chk({nm, "_hit"}, 64'(bus.hit_o), 64'(eh));
      chk({nm, "_miss"}, 64'(bus.miss_o), 64'(em));
      chk({nm, "_data"}, 64'(bus.data_o), 64'(ed));
   endtask

   // Miss on tag t, feed 8 beats (optionally with an idle cycle before each), check the
   // COMMIT pulse timing and the hit that follows. inv_commit raises invalidate in COMMIT.
   task automatic do_refill(input string nm, input logic [19:0] t, input logic [31:0] base,
                            input bit gap, input bit inv_commit);
      @(negedge clk);
      bus.active_set_i = 1'b1;
      bus.tag_i        = t;
      bus.block_i      = 6'h00;
      bus.rep_enable_i = 1'b1;
      bus.l2_valid_i   = 1'b0;
      bus.invalidate_i = 1'b0;
      #1;
      chk({nm, "_miss"}, 64'(bus.miss_o), 64'd1);
      chk({nm, "_idle"}, 64'(bus.busy_o), 64'd0);
      for (int k = 0; k < 8; k++) begin
         if (gap) begin
            @(negedge clk);
            bus.l2_valid_i = 1'b0;
            bus.l2_data_i  = '1;
            #1;
            chk($sformatf("%s_gapreq%0d", nm, k), 64'(bus.refill_req_o), 64'd1);
            chk($sformatf("%s_gapdone%0d", nm, k), 64'(bus.refill_done_o), 64'd0);
         end
         @(negedge clk);
         bus.l2_valid_i = 1'b1;
         bus.l2_data_i  = beat(base, k);
         #1;
         chk($sformatf("%s_req%0d", nm, k), 64'(bus.refill_req_o), 64'd1);
         chk($sformatf("%s_done%0d", nm, k), 64'(bus.refill_done_o), 64'd0);
         chk($sformatf("%s_fhit%0d", nm, k), 64'(bus.hit_o), 64'd0);
      end
      @(negedge clk);
      bus.l2_valid_i   = 1'b0;
      bus.rep_enable_i = 1'b0;
      bus.invalidate_i = inv_commit;
      #1;
      chk({nm, "_commit_done"}, 64'(bus.refill_done_o), 64'd1);
      chk({nm, "_commit_req"}, 64'(bus.refill_req_o), 64'd0);
      chk({nm, "_commit_busy"}, 64'(bus.busy_o), 64'd1);
      @(negedge clk);
      bus.invalidate_i = 1'b0;
      #1;
      chk({nm, "_after_done"}, 64'(bus.refill_done_o), 64'd0);
      chk({nm, "_after_busy"}, 64'(bus.busy_o), 64'd0);
      chk({nm, "_after_hit"}, 64'(bus.hit_o), 64'(!inv_commit));
   endtask

   task automatic partial_fill(input logic [19:0] t, input int nbeats);
      @(negedge clk);
      bus.active_set_i = 1'b1;
      bus.tag_i        = t;
      bus.rep_enable_i = 1'b1;
      bus.l2_valid_i   = 1'b0;
      for (int k = 0; k < nbeats; k++) begin
         @(negedge clk);
         bus.rep_enable_i = 1'b0;
         bus.l2_valid_i   = 1'b1;
         bus.l2_data_i    = beat(32'hDEAD_0000, k);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      vecs[0]  = '{1'b1, 20'h12345, 6'h00, 1'b1, 1'b0, 32'h0000_0000};
      vecs[1]  = '{1'b1, 20'h12345, 6'h3C, 1'b1, 1'b0, 32'h0000_000F};
      vecs[2]  = '{1'b1, 20'h0000C, 6'h04, 1'b1, 1'b0, 32'h0000_2001};
      vecs[3]  = '{1'b1, 20'h0000C, 6'h20, 1'b1, 1'b0, 32'h0000_2008};
      vecs[4]  = '{1'b1, 20'h0000D, 6'h1C, 1'b1, 1'b0, 32'h0000_3007};
      vecs[5]  = '{1'b1, 20'h0000D, 6'h3F, 1'b1, 1'b0, 32'h0000_300F};
      vecs[6]  = '{1'b1, 20'h0000E, 6'h10, 1'b1, 1'b0, 32'h0000_5004};
      vecs[7]  = '{1'b1, 20'h0000E, 6'h2A, 1'b1, 1'b0, 32'h0000_500A};
      vecs[8]  = '{1'b1, 20'h0000B, 6'h00, 1'b0, 1'b1, 32'h0000_0000};
      vecs[9]  = '{1'b1, 20'h77777, 6'h08, 1'b0, 1'b1, 32'h0000_0000};
      vecs[10] = '{1'b0, 20'h12345, 6'h04, 1'b0, 1'b0, 32'h0000_0000};
      vecs[11] = '{1'b1, 20'h0000D, 6'h00, 1'b1, 1'b0, 32'h0000_3000};

      rst_n            = 1'b0;
      bus.active_set_i = 1'b1;
      bus.rep_enable_i = 1'b0;
      bus.block_i      = '0;
      bus.tag_i        = 20'h12345;
      bus.invalidate_i = 1'b0;
      bus.l2_valid_i   = 1'b0;
      bus.l2_data_i    = '0;
      #2;
      chk("rst_busy", 64'(bus.busy_o), 64'd0);
      chk("rst_req", 64'(bus.refill_req_o), 64'd0);
      chk("rst_done", 64'(bus.refill_done_o), 64'd0);
      chk("rst_hit", 64'(bus.hit_o), 64'd0);
      chk("rst_miss", 64'(bus.miss_o), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // First refill into way 0, then the word at byte 0x0C.
      do_refill("fillA", 20'h12345, 32'h0000_0000, 1'b0, 1'b0);
      lookup("readA", 1'b1, 20'h12345, 6'h0C, 1'b1, 1'b0, 32'h0000_0003);

      // Fill ways 1..3, touch A, then E must evict B (way 1, oldest).
      do_refill("fillB", 20'h0000B, 32'h0000_1000, 1'b0, 1'b0);
      do_refill("fillC", 20'h0000C, 32'h0000_2000, 1'b0, 1'b0);
      do_refill("fillD", 20'h0000D, 32'h0000_3000, 1'b0, 1'b0);
      lookup("touchA", 1'b1, 20'h12345, 6'h00, 1'b1, 1'b0, 32'h0000_0000);
      do_refill("fillE", 20'h0000E, 32'h0000_5000, 1'b0, 1'b0);

      for (int i = 0; i < NV; i++) begin
         lookup($sformatf("vec%0d", i), vecs[i].act, vecs[i].tag, vecs[i].blk,
                vecs[i].exp_hit, vecs[i].exp_miss, vecs[i].exp_data);
      end

      // Miss without rep_enable must not start a refill.
      lookup("norep", 1'b1, 20'h99999, 6'h00, 1'b0, 1'b1, 32'h0);
      @(negedge clk);
      #1;
      chk("norep_busy", 64'(bus.busy_o), 64'd0);

      // Ages are now A=3,E=1,C=2,D=0: F with stalled beats replaces A.
      do_refill("fillF", 20'h0000F, 32'h0000_6000, 1'b1, 1'b0);
      lookup("Agone", 1'b1, 20'h12345, 6'h00, 1'b0, 1'b1, 32'h0);
      lookup("readF", 1'b1, 20'h0000F, 6'h24, 1'b1, 1'b0, 32'h0000_6009);
      lookup("readE", 1'b1, 20'h0000E, 6'h00, 1'b1, 1'b0, 32'h0000_5000);

      // Invalidate while beat 4 is offered aborts the refill and clears all ways.
      partial_fill(20'h00066, 4);
      @(negedge clk);
      bus.l2_valid_i   = 1'b1;
      bus.l2_data_i    = beat(32'hDEAD_0000, 4);
      bus.invalidate_i = 1'b1;
      #1;
      chk("abort_busy_before", 64'(bus.busy_o), 64'd1);
      @(negedge clk);
      bus.invalidate_i = 1'b0;
      bus.l2_valid_i   = 1'b0;
      #1;
      chk("abort_busy", 64'(bus.busy_o), 64'd0);
      chk("abort_req", 64'(bus.refill_req_o), 64'd0);
      lookup("abortG", 1'b1, 20'h00066, 6'h00, 1'b0, 1'b1, 32'h0);
      lookup("abortE", 1'b1, 20'h0000E, 6'h00, 1'b0, 1'b1, 32'h0);
      lookup("abortF", 1'b1, 20'h0000F, 6'h00, 1'b0, 1'b1, 32'h0);
      lookup("abortD", 1'b1, 20'h0000D, 6'h00, 1'b0, 1'b1, 32'h0);

      // Asynchronous reset between edges after beat 3, then a clean refill from beat 0.
      partial_fill(20'h00077, 3);
      @(negedge clk);
      bus.l2_valid_i = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_busy", 64'(bus.busy_o), 64'd0);
      chk("mrst_req", 64'(bus.refill_req_o), 64'd0);
      chk("mrst_done", 64'(bus.refill_done_o), 64'd0);
      chk("mrst_hit", 64'(bus.hit_o), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_refill("fillH", 20'h00077, 32'h0000_7000, 1'b0, 1'b0);
      lookup("readH0", 1'b1, 20'h00077, 6'h00, 1'b1, 1'b0, 32'h0000_7000);
      lookup("readH15", 1'b1, 20'h00077, 6'h3C, 1'b1, 1'b0, 32'h0000_700F);
      lookup("readH7", 1'b1, 20'h00077, 6'h1C, 1'b1, 1'b0, 32'h0000_7007);

      // Invalidate during COMMIT overrides the new valid bit.
      do_refill("fillJ", 20'h000AA, 32'h0000_8000, 1'b0, 1'b1);
      lookup("Jgone", 1'b1, 20'h000AA, 6'h00, 1'b0, 1'b1, 32'h0);
      lookup("Hgone", 1'b1, 20'h00077, 6'h00, 1'b0, 1'b1, 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
